// File: rtl/phy_tx_lane_arbiter_pkg.sv
// Shared constants for the PHY transmit lane arbiter: FSM encodings, the COM idle
// symbol rendered downstream for valid_out=0 cycles, and the round-robin index helper.
package phy_tx_lane_arbiter_pkg;

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    localparam logic [7:0] COM_SYMBOL = 8'hBC;

    // Candidate index 'offset' places after 'base', wrapping at n.
    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/phy_rr_pick.sv
// Combinational round-robin picker: returns the first requester after last_grant,
// wrapping around, so the previous grantee has the lowest priority.
module phy_rr_pick
    import phy_tx_lane_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0] pick_oh,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_any
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Scanning offsets 1..N_REQ visits last_grant itself last, so a lone lane can still win.
    always_comb begin
        pick_oh  = '0;
        pick_idx = last_grant;
        pick_any = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand     = rr_index(int'(last_grant), k, N_REQ);
            cand_idx = IDX_W'(cand);
            if (!pick_any && req[cand_idx]) begin
                pick_any          = 1'b1;
                pick_idx          = cand_idx;
                pick_oh[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/phy_tx_lane_arbiter.sv
// Round-robin scheduler sharing the PHY transmit byte path between N_REQ requester FIFOs,
// with a COM preamble after reset, inter-packet COM gaps and per-grant burst limiting.
module phy_tx_lane_arbiter
    import phy_tx_lane_arbiter_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_W     = 8,
    parameter int INIT_COMS  = 4,
    parameter int GAP_CYCLES = 1,
    parameter int MAX_BURST  = 16
) (
    input  logic                       cclk,
    input  logic                       reset_L,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_pop,
    output logic                       valid_out,
    output logic [DATA_W-1:0]          data_out,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       link_up,
    output logic                       busy
);

    localparam int IDX_W   = $clog2(N_REQ);
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int INIT_W  = (INIT_COMS > 0) ? $clog2(INIT_COMS + 1) : 1;
    localparam int GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [N_REQ-1:0]   OH_LAST    = {1'b1, {(N_REQ-1){1'b0}}};
    localparam logic [BURST_W-1:0] BURST_LIM  = BURST_W'(MAX_BURST);

    logic [1:0]         state;
    logic [N_REQ-1:0]   grant_oh;
    logic [BURST_W-1:0] burst_cnt;
    logic [BURST_W-1:0] burst_nxt;
    logic [INIT_W-1:0]  init_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    logic [N_REQ-1:0]   pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic [DATA_W-1:0]  lane_data;
    logic               lane_last;
    logic               lane_pop;

    phy_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req        (req_valid),
        .last_grant (grant_id),
        .pick_oh    (pick_oh),
        .pick_idx   (pick_idx),
        .pick_any   (pick_any)
    );

    // The one-hot grant register lets the byte/last mux stay a simple AND-OR tree.
    always_comb begin
        lane_data = '0;
        lane_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_oh[i]) begin
                lane_data = lane_data | req_data[i*DATA_W +: DATA_W];
                lane_last = lane_last | req_last[i];
            end
        end
    end

    assign req_pop   = (state == ST_XFER) ? (req_valid & grant_oh) : '0;
    assign lane_pop  = |req_pop;
    assign burst_nxt = burst_cnt + BURST_W'(1);

    always_ff @(posedge cclk or negedge reset_L) begin
        if (!reset_L) begin
            state     <= ST_INIT;
            valid_out <= 1'b0;
            data_out  <= '0;
            link_up   <= 1'b0;
            busy      <= 1'b0;
            grant_id  <= IDX_W'(N_REQ - 1);
            grant_oh  <= OH_LAST;
            burst_cnt <= '0;
            init_cnt  <= '0;
            gap_cnt   <= '0;
        end else begin
            valid_out <= 1'b0;
            data_out  <= '0;
            case (state)
                ST_INIT: begin
                    if (int'(init_cnt) + 1 >= INIT_COMS) begin
                        link_up <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        init_cnt <= init_cnt + INIT_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_id  <= pick_idx;
                        grant_oh  <= pick_oh;
                        burst_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    // An underrun simply emits an idle byte and keeps the grant.
                    if (lane_pop) begin
                        valid_out <= 1'b1;
                        data_out  <= lane_data;
                        burst_cnt <= burst_nxt;
                        if (lane_last || (burst_nxt == BURST_LIM)) begin
                            gap_cnt <= '0;
                            if (GAP_CYCLES > 0) begin
                                state <= ST_GAP;
                            end else begin
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (int'(gap_cnt) + 1 >= GAP_CYCLES) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phy_tx_lane_arbiter.sv
// Directed bench for phy_tx_lane_arbiter: per-lane FIFO models feed the requesters and
// every observed output is compared against hand-computed expectations.
module tb_phy_tx_lane_arbiter;

    logic        cclk;
    logic        reset_L;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_pop;
    logic        valid_out;
    logic [7:0]  data_out;
    logic [1:0]  grant_id;
    logic        link_up;
    logic        busy;

    int n_cmp;
    int n_bad;
    int cyc;

    logic [7:0] lane_byte [4][32];
    logic       lane_lst  [4][32];
    int         lane_rd   [4];
    int         lane_wr   [4];
    logic [3:0] lane_hold;
    logic [3:0] pop_seen;

    logic [7:0] out_data [64];
    logic [1:0] out_gid  [64];
    int         out_cyc  [64];
    int         out_n;

    phy_tx_lane_arbiter #(
        .N_REQ      (4),
        .DATA_W     (8),
        .INIT_COMS  (4),
        .GAP_CYCLES (1),
        .MAX_BURST  (16)
    ) dut (
        .cclk      (cclk),
        .reset_L   (reset_L),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_pop   (req_pop),
        .valid_out (valid_out),
        .data_out  (data_out),
        .grant_id  (grant_id),
        .link_up   (link_up),
        .busy      (busy)
    );

    initial begin
        cclk = 1'b0;
        forever #5 cclk = ~cclk;
    end

    task automatic clear_lanes();
        for (int i = 0; i < 4; i++) begin
            lane_rd[i] = 0;
            lane_wr[i] = 0;
        end
        lane_hold = 4'b0000;
        pop_seen  = 4'b0000;
        out_n     = 0;
    endtask

    task automatic push(input int lane, input logic [7:0] b, input logic l);
        lane_byte[lane][lane_wr[lane]] = b;
        lane_lst[lane][lane_wr[lane]]  = l;
        lane_wr[lane]++;
    endtask

    task automatic drive_lanes();
        logic v;
        for (int i = 0; i < 4; i++) begin
            v = (lane_rd[i] < lane_wr[i]) && !lane_hold[i];
            req_valid[i]        = v;
            req_data[i*8 +: 8]  = v ? lane_byte[i][lane_rd[i]] : 8'h00;
            req_last[i]         = v && lane_lst[i][lane_rd[i]];
        end
    endtask

    // Advance to the next falling edge, retire bytes the DUT popped, present new heads, sample.
    task automatic step();
        @(negedge cclk);
        for (int i = 0; i < 4; i++)
            if (pop_seen[i] && lane_rd[i] < lane_wr[i]) lane_rd[i]++;
        drive_lanes();
        #1;
        cyc++;
        pop_seen = req_pop;
        if (valid_out && out_n < 64) begin
            out_data[out_n] = data_out;
            out_gid[out_n]  = grant_id;
            out_cyc[out_n]  = cyc;
            out_n++;
        end
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        clear_lanes();
        drive_lanes();
        @(negedge cclk);
        @(negedge cclk);
        reset_L = 1'b1;
        #1;
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_out); end
        n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_data: got %h expected 00", data_out); end
        n_cmp++; if (link_up !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_link: got %b expected 0", link_up); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (grant_id !== 2'd3) begin n_bad++; $display("[TB] FAIL reset_grant: got %0d expected 3", grant_id); end
        for (int k = 1; k <= 4; k++) begin
            step();
            n_cmp++; if (link_up !== (k >= 4)) begin n_bad++; $display("[TB] FAIL init_link k=%0d: got %b expected %b", k, link_up, (k >= 4)); end
            n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("[TB] FAIL init_valid k=%0d: got %b expected 0", k, valid_out); end
            n_cmp++; if (req_pop !== 4'b0000) begin n_bad++; $display("[TB] FAIL init_pop k=%0d: got %b expected 0000", k, req_pop); end
        end
    endtask

    task automatic do_reset();
        int waited;
        reset_L = 1'b0;
        #1;
        clear_lanes();
        drive_lanes();
        @(negedge cclk);
        reset_L = 1'b1;
        waited = 0;
        while (!link_up && waited < 10) begin
            step();
            waited++;
        end
        n_cmp++; if (link_up !== 1'b1) begin n_bad++; $display("[TB] FAIL relink: got %b expected 1 after %0d cycles", link_up, waited); end
    endtask

    task automatic test_single_packet();
        logic [3:0] exp_pop   [6];
        logic       exp_valid [6];
        logic [7:0] exp_data  [6];
        logic       exp_busy  [6];
        clear_lanes();
        push(2, 8'hA1, 1'b0);
        push(2, 8'hA2, 1'b0);
        push(2, 8'hA3, 1'b1);
        exp_pop   = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        exp_valid = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_data  = '{8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'h00};
        exp_busy  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int s = 0; s < 6; s++) begin
            step();
            n_cmp++; if (req_pop !== exp_pop[s]) begin n_bad++; $display("[TB] FAIL pkt_pop s=%0d: got %b expected %b", s, req_pop, exp_pop[s]); end
            n_cmp++; if (valid_out !== exp_valid[s]) begin n_bad++; $display("[TB] FAIL pkt_valid s=%0d: got %b expected %b", s, valid_out, exp_valid[s]); end
            n_cmp++; if (data_out !== exp_data[s]) begin n_bad++; $display("[TB] FAIL pkt_data s=%0d: got %h expected %h", s, data_out, exp_data[s]); end
            n_cmp++; if (busy !== exp_busy[s]) begin n_bad++; $display("[TB] FAIL pkt_busy s=%0d: got %b expected %b", s, busy, exp_busy[s]); end
            if (s >= 1) begin
                n_cmp++; if (grant_id !== 2'd2) begin n_bad++; $display("[TB] FAIL pkt_grant s=%0d: got %0d expected 2", s, grant_id); end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [6];
        logic [1:0] exp_g [6];
        do_reset();
        clear_lanes();
        push(0, 8'h10, 1'b1); push(0, 8'h11, 1'b1);
        push(1, 8'h20, 1'b1); push(1, 8'h21, 1'b1);
        push(3, 8'h40, 1'b1); push(3, 8'h41, 1'b1);
        exp_d = '{8'h10, 8'h20, 8'h40, 8'h11, 8'h21, 8'h41};
        exp_g = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
        for (int s = 0; s < 24; s++) step();
        n_cmp++; if (out_n !== 6) begin n_bad++; $display("[TB] FAIL rr_count: got %0d expected 6", out_n); end
        for (int k = 0; k < 6 && k < out_n; k++) begin
            n_cmp++; if (out_gid[k] !== exp_g[k]) begin n_bad++; $display("[TB] FAIL rr_grant k=%0d: got %0d expected %0d", k, out_gid[k], exp_g[k]); end
            n_cmp++; if (out_data[k] !== exp_d[k]) begin n_bad++; $display("[TB] FAIL rr_data k=%0d: got %h expected %h", k, out_data[k], exp_d[k]); end
        end
        if (out_n >= 2) begin
            n_cmp++; if (out_cyc[1] - out_cyc[0] !== 3) begin n_bad++; $display("[TB] FAIL rr_spacing: got %0d expected 3", out_cyc[1] - out_cyc[0]); end
        end
    endtask

    task automatic test_burst_limit();
        clear_lanes();
        for (int k = 0; k < 20; k++) push(1, 8'(8'h60 + k), (k == 19));
        for (int s = 0; s < 30; s++) step();
        n_cmp++; if (out_n !== 20) begin n_bad++; $display("[TB] FAIL burst_count: got %0d expected 20", out_n); end
        for (int k = 0; k < 20 && k < out_n; k++) begin
            n_cmp++; if (out_data[k] !== 8'(8'h60 + k) || out_gid[k] !== 2'd1) begin
                n_bad++; $display("[TB] FAIL burst_byte k=%0d: got %h/lane %0d expected %h/lane 1", k, out_data[k], out_gid[k], 8'(8'h60 + k));
            end
        end
        if (out_n >= 17) begin
            n_cmp++; if (out_cyc[15] - out_cyc[0] !== 15) begin n_bad++; $display("[TB] FAIL burst_run: got %0d expected 15", out_cyc[15] - out_cyc[0]); end
            n_cmp++; if (out_cyc[16] - out_cyc[15] !== 3) begin n_bad++; $display("[TB] FAIL burst_release_gap: got %0d expected 3", out_cyc[16] - out_cyc[15]); end
        end
    endtask

    task automatic test_underrun();
        clear_lanes();
        for (int k = 0; k < 6; k++) push(0, 8'(8'h80 + k), (k == 5));
        for (int s = 1; s <= 12; s++) begin
            lane_hold[0] = (s == 4 || s == 5);
            step();
            if (s == 4) begin
                n_cmp++; if (req_pop !== 4'b0000) begin n_bad++; $display("[TB] FAIL under_pop: got %b expected 0000", req_pop); end
            end
            if (s == 5 || s == 6) begin
                n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("[TB] FAIL under_valid s=%0d: got %b expected 0", s, valid_out); end
                n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("[TB] FAIL under_data s=%0d: got %h expected 00", s, data_out); end
                n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("[TB] FAIL under_grant s=%0d: got %0d expected 0", s, grant_id); end
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL under_busy s=%0d: got %b expected 1", s, busy); end
            end
        end
        n_cmp++; if (out_n !== 6) begin n_bad++; $display("[TB] FAIL under_count: got %0d expected 6", out_n); end
        for (int k = 0; k < 6 && k < out_n; k++) begin
            n_cmp++; if (out_data[k] !== 8'(8'h80 + k)) begin n_bad++; $display("[TB] FAIL under_byte k=%0d: got %h expected %h", k, out_data[k], 8'(8'h80 + k)); end
        end
        if (out_n >= 3) begin
            n_cmp++; if (out_cyc[2] - out_cyc[1] !== 3) begin n_bad++; $display("[TB] FAIL under_hole: got %0d expected 3", out_cyc[2] - out_cyc[1]); end
        end
    endtask

    task automatic test_async_reset();
        clear_lanes();
        for (int k = 0; k < 8; k++) push(2, 8'(8'hC0 + k), (k == 7));
        step();
        step();
        step();
        n_cmp++; if (valid_out !== 1'b1 || data_out !== 8'hC0) begin n_bad++; $display("[TB] FAIL areset_pre: got %b/%h expected 1/c0", valid_out, data_out); end
        #2;
        reset_L = 1'b0;
        #1;
        pop_seen = 4'b0000;
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("[TB] FAIL areset_valid: got %b expected 0", valid_out); end
        n_cmp++; if (link_up !== 1'b0) begin n_bad++; $display("[TB] FAIL areset_link: got %b expected 0", link_up); end
        n_cmp++; if (req_pop !== 4'b0000) begin n_bad++; $display("[TB] FAIL areset_pop: got %b expected 0000", req_pop); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL areset_busy: got %b expected 0", busy); end
        step();
        step();
        reset_L = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_cmp++; if (link_up !== (k >= 4)) begin n_bad++; $display("[TB] FAIL rinit_link k=%0d: got %b expected %b", k, link_up, (k >= 4)); end
            n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("[TB] FAIL rinit_valid k=%0d: got %b expected 0", k, valid_out); end
            n_cmp++; if (req_pop !== 4'b0000) begin n_bad++; $display("[TB] FAIL rinit_pop k=%0d: got %b expected 0000", k, req_pop); end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        cyc       = 0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_burst_limit();
        test_underrun();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
